pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It produces every stall, bubble and flush for the pipeline registers, covering load-use hazards, taken-branch/jump redirects and multi-cycle mul/div occupancy of EX. It also generates operand forwarding selects and keeps saturating performance counters. It replaces the standalone load-use check and is the only block allowed to drive pipeline-register enables and flushes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the operand-forward select codes, the
// default mul/div timeout, and the forward-select helper used per source.
package pipeline_hazard_ctrl_pkg;

  typedef logic [0:0] state_t;
  localparam state_t RUN     = 1'b0;
  localparam state_t MD_WAIT = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int MD_TIMEOUT_DEF = 64;

  // MEM beats WB; x0 never forwards because it is never written.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_mem,
                                         input logic       we_mem,
                                         input logic [4:0] rd_wb,
                                         input logic       we_wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (we_mem && (rd_mem == rs))      sel = FWD_MEM;
      else if (we_wb && (rd_wb == rs))   sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating event counter.
// Ports: clk, rst (sync, active-high clear), inc (count this cycle),
//        count (current value, holds at all-ones).
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline.
// Generates stall/bubble/flush controls for load-use, taken redirects and
// multi-cycle mul/div occupancy of EX, plus operand-forward selects and
// saturating stall/flush performance counters.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   rs1_ID/rs2_ID, Rs*_Valid_ID   ID source registers and read flags
//   rd_*/Write_Enable_*           destination + write pending per stage
//   I_Type_Load_EX, MulDiv_EX     EX instruction class
//   Branch_Taken_EX               EX resolved a redirect
//   md_done                       mul/div result valid pulse
//   stall_IF/ID/EX, bubble_EX/MEM, flush_ID  pipeline-register controls
//   md_start                      mul/div launch pulse
//   fwd_rs1/fwd_rs2               0 regfile, 1 MEM, 2 WB
//   md_error                      sticky mul/div timeout flag
//   stall_cnt/flush_cnt           saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             Rs1_Valid_ID,
  input  logic             Rs2_Valid_ID,
  input  logic [4:0]       rd_EX,
  input  logic [4:0]       rd_MEM,
  input  logic [4:0]       rd_WB,
  input  logic             Write_Enable_EX,
  input  logic             Write_Enable_MEM,
  input  logic             Write_Enable_WB,
  input  logic             I_Type_Load_EX,
  input  logic             MulDiv_EX,
  input  logic             Branch_Taken_EX,
  input  logic             md_done,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             bubble_EX,
  output logic             bubble_MEM,
  output logic             flush_ID,
  output logic             md_start,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic in_run, in_wait;
  logic load_use, redirect, md_timeout, md_hold;

  assign in_run  = (state == RUN);
  assign in_wait = (state == MD_WAIT);

  // rd_EX != 0 also excludes rs == 0, since a match requires equality.
  assign load_use = in_run && Write_Enable_EX && I_Type_Load_EX && (rd_EX != 5'd0) &&
                    ((Rs1_Valid_ID && (rs1_ID == rd_EX)) ||
                     (Rs2_Valid_ID && (rs2_ID == rd_EX)));
  assign redirect = in_run && Branch_Taken_EX;

  // md_done in the timeout cycle wins, so the timeout only fires without it.
  assign md_timeout = in_wait && !md_done && (wait_cnt == WAIT_LAST);
  assign md_hold    = in_wait && !md_done && !md_timeout;

  // Controls are forced low while rst is asserted.
  always_comb begin
    stall_IF   = 1'b0;
    stall_ID   = 1'b0;
    stall_EX   = 1'b0;
    bubble_EX  = 1'b0;
    bubble_MEM = 1'b0;
    flush_ID   = 1'b0;
    md_start   = 1'b0;
    fwd_rs1    = FWD_RF;
    fwd_rs2    = FWD_RF;
    if (!rst) begin
      // A redirect squashes the ID instruction, so its load-use stall is moot.
      stall_IF   = md_hold || (load_use && !redirect);
      stall_ID   = md_hold || (load_use && !redirect);
      stall_EX   = md_hold;
      bubble_EX  = redirect || load_use;
      bubble_MEM = md_hold;
      flush_ID   = redirect;
      md_start   = in_run && MulDiv_EX;
      fwd_rs1    = fwd_sel(rs1_ID, rd_MEM, Write_Enable_MEM, rd_WB, Write_Enable_WB);
      fwd_rs2    = fwd_sel(rs2_ID, rd_MEM, Write_Enable_MEM, rd_WB, Write_Enable_WB);
    end
  end

  // FSM / wait counter / sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      md_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            state    <= MD_WAIT;
            wait_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (md_done || md_timeout)
            state <= RUN;
          else
            wait_cnt <= wait_cnt + WAIT_W'(1);
          if (md_timeout)
            md_error <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_ID),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ID),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN-state
// vectors followed by hand-written mul/div, timeout and reset sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM, rd_WB;
  logic       Rs1_Valid_ID, Rs2_Valid_ID;
  logic       Write_Enable_EX, Write_Enable_MEM, Write_Enable_WB;
  logic       I_Type_Load_EX, MulDiv_EX, Branch_Taken_EX, md_done;
  logic       stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEM, flush_ID, md_start;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       md_error;
  logic [3:0] stall_cnt, flush_cnt;

  logic [10:0] ctl;
  assign ctl = {stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEM, flush_ID,
                md_start, fwd_rs1, fwd_rs2};

  int errors = 0;
  int checks = 0;
  int exp_st = 0;
  int exp_fl = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .Rs1_Valid_ID(Rs1_Valid_ID), .Rs2_Valid_ID(Rs2_Valid_ID),
    .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .Write_Enable_EX(Write_Enable_EX), .Write_Enable_MEM(Write_Enable_MEM),
    .Write_Enable_WB(Write_Enable_WB),
    .I_Type_Load_EX(I_Type_Load_EX), .MulDiv_EX(MulDiv_EX),
    .Branch_Taken_EX(Branch_Taken_EX), .md_done(md_done),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM), .flush_ID(flush_ID),
    .md_start(md_start), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .md_error(md_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       v1, v2;
    logic [4:0] rde, rdm, rdw;
    logic       we_e, we_m, we_w, ld, br;
    logic       st, bub, fl;
    logic [1:0] f1, f2;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic v1, input logic v2,
                              input logic [4:0] rde, input logic [4:0] rdm,
                              input logic [4:0] rdw,
                              input logic we_e, input logic we_m, input logic we_w,
                              input logic ld, input logic br,
                              input logic st, input logic bub, input logic fl,
                              input logic [1:0] f1, input logic [1:0] f2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.v1 = v1; v.v2 = v2;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.we_e = we_e; v.we_m = we_m; v.we_w = we_w; v.ld = ld; v.br = br;
    v.st = st; v.bub = bub; v.fl = fl; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  // Expected control word in the same order as ctl.
  function automatic logic [10:0] e(input logic sif, input logic sid, input logic sex,
                                    input logic bex, input logic bmem, input logic fl,
                                    input logic mds, input logic [1:0] f1,
                                    input logic [1:0] f2);
    return {sif, sid, sex, bex, bmem, fl, mds, f1, f2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; Rs1_Valid_ID = 1'b0; Rs2_Valid_ID = 1'b0;
    rd_EX = 5'd0; rd_MEM = 5'd0; rd_WB = 5'd0;
    Write_Enable_EX = 1'b0; Write_Enable_MEM = 1'b0; Write_Enable_WB = 1'b0;
    I_Type_Load_EX = 1'b0; MulDiv_EX = 1'b0; Branch_Taken_EX = 1'b0; md_done = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs1_ID = v.rs1; rs2_ID = v.rs2; Rs1_Valid_ID = v.v1; Rs2_Valid_ID = v.v2;
    rd_EX = v.rde; rd_MEM = v.rdm; rd_WB = v.rdw;
    Write_Enable_EX = v.we_e; Write_Enable_MEM = v.we_m; Write_Enable_WB = v.we_w;
    I_Type_Load_EX = v.ld; Branch_Taken_EX = v.br;
    MulDiv_EX = 1'b0; md_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rs1 rs2 v1 v2 rdE rdM rdW weE weM weW ld br  st bub fl f1 f2
    vecs[0]  = mk(7,  5,  1, 1, 5,  0,  0,  1,  0,  0,  1, 0,  1, 1, 0, 0, 0); // load-use rs2
    vecs[1]  = mk(9,  0,  1, 0, 9,  0,  0,  1,  0,  0,  1, 0,  1, 1, 0, 0, 0); // load-use rs1
    vecs[2]  = mk(9,  0,  0, 0, 9,  0,  0,  1,  0,  0,  1, 0,  0, 0, 0, 0, 0); // source not read
    vecs[3]  = mk(0,  0,  1, 0, 0,  0,  0,  1,  0,  0,  1, 0,  0, 0, 0, 0, 0); // load to x0
    vecs[4]  = mk(9,  0,  1, 0, 9,  0,  0,  1,  0,  0,  0, 0,  0, 0, 0, 0, 0); // not a load
    vecs[5]  = mk(9,  0,  1, 0, 9,  0,  0,  0,  0,  0,  1, 0,  0, 0, 0, 0, 0); // load w/o write
    vecs[6]  = mk(7,  5,  1, 1, 5,  0,  0,  1,  0,  0,  1, 1,  0, 1, 1, 0, 0); // branch + load-use
    vecs[7]  = mk(0,  0,  0, 0, 0,  0,  0,  0,  0,  0,  0, 1,  0, 1, 1, 0, 0); // branch alone
    vecs[8]  = mk(3,  0,  1, 0, 0,  3,  3,  0,  1,  1,  0, 0,  0, 0, 0, 1, 0); // MEM over WB
    vecs[9]  = mk(3,  0,  1, 0, 0,  3,  3,  0,  0,  1,  0, 0,  0, 0, 0, 2, 0); // WB only
    vecs[10] = mk(4,  6,  1, 1, 0,  6,  4,  0,  1,  1,  0, 0,  0, 0, 0, 2, 1); // split sources
    vecs[11] = mk(0,  8,  1, 1, 0,  0,  8,  0,  1,  0,  0, 0,  0, 0, 0, 0, 0); // x0 / no write
    vecs[12] = mk(5,  5,  1, 1, 5,  0,  0,  1,  0,  0,  1, 0,  1, 1, 0, 0, 0); // both sources
    vecs[13] = mk(1,  2,  1, 1, 0,  2,  1,  0,  1,  1,  0, 0,  0, 0, 0, 2, 1); // fwd both

    // Reset with hazards present: every control must be low.
    idle();
    rst = 1'b1;
    rs1_ID = 5'd5; Rs1_Valid_ID = 1'b1; rd_EX = 5'd5; Write_Enable_EX = 1'b1;
    I_Type_Load_EX = 1'b1; Branch_Taken_EX = 1'b1; MulDiv_EX = 1'b1;
    rd_MEM = 5'd5; Write_Enable_MEM = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_ctl", 32'(ctl), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_md_error", 32'(md_error), 32'd0);
    next_cycle();
    idle();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      apply(vecs[i]);
      #3;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl),
          32'(e(vecs[i].st, vecs[i].st, 1'b0, vecs[i].bub, 1'b0, vecs[i].fl, 1'b0,
                vecs[i].f1, vecs[i].f2)));
      exp_st += int'(vecs[i].st);
      exp_fl += int'(vecs[i].fl);
    end
    next_cycle();
    idle();
    #3;
    chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_st));
    chk("table_flush_cnt", 32'(flush_cnt), 32'(exp_fl));

    // Mul/div, md_done on the sixth MD_WAIT cycle: five stalled cycles.
    next_cycle();
    MulDiv_EX = 1'b1;
    #3;
    chk("md_start_pulse", 32'(ctl), 32'(e(0, 0, 0, 0, 0, 0, 1, 0, 0)));
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      Branch_Taken_EX = (c == 3);
      rs1_ID = (c == 3) ? 5'd12 : 5'd0;
      Rs1_Valid_ID = (c == 3);
      rd_EX = (c == 3) ? 5'd12 : 5'd0;
      Write_Enable_EX = (c == 3);
      I_Type_Load_EX = (c == 3);
      #3;
      chk($sformatf("md_hold_c%0d", c), 32'(ctl), 32'(e(1, 1, 1, 0, 1, 0, 0, 0, 0)));
    end
    next_cycle();
    idle();
    MulDiv_EX = 1'b1;
    md_done = 1'b1;
    #3;
    chk("md_done_release", 32'(ctl), 32'd0);
    next_cycle();
    idle();
    rs1_ID = 5'd12; Rs1_Valid_ID = 1'b1; rd_EX = 5'd12;
    Write_Enable_EX = 1'b1; I_Type_Load_EX = 1'b1;
    #3;
    chk("run_after_md", 32'(ctl), 32'(e(1, 1, 0, 1, 0, 0, 0, 0, 0)));
    next_cycle();
    idle();
    md_done = 1'b1;
    #3;
    chk("md_done_in_run", 32'(ctl), 32'd0);
    chk("md_stall_cnt", 32'(stall_cnt), 32'(exp_st + 6));
    chk("md_flush_cnt", 32'(flush_cnt), 32'(exp_fl));

    // Timeout: 7 stalled cycles, stalls drop on the 8th, error sticks.
    next_cycle();
    idle();
    MulDiv_EX = 1'b1;
    #3;
    chk("to_md_start", 32'(ctl), 32'(e(0, 0, 0, 0, 0, 0, 1, 0, 0)));
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      #3;
      if (c == 7)
        chk("to_hold_last", 32'(ctl), 32'(e(1, 1, 1, 0, 1, 0, 0, 0, 0)));
    end
    next_cycle();
    #3;
    chk("to_release", 32'(ctl), 32'd0);
    chk("to_error_not_yet", 32'(md_error), 32'd0);
    next_cycle();
    MulDiv_EX = 1'b0;
    #3;
    chk("to_md_error", 32'(md_error), 32'd1);
    chk("to_stall_cnt_sat", 32'(stall_cnt), 32'd15);
    chk("to_back_in_run", 32'(ctl), 32'd0);
    next_cycle();
    #3;
    chk("to_error_sticky", 32'(md_error), 32'd1);

    // Reset in the middle of MD_WAIT.
    next_cycle();
    MulDiv_EX = 1'b1;
    next_cycle();
    #3;
    chk("rst_pre_hold", 32'(ctl), 32'(e(1, 1, 1, 0, 1, 0, 0, 0, 0)));
    next_cycle();
    rst = 1'b1;
    MulDiv_EX = 1'b0;
    #3;
    chk("rst_mid_ctl", 32'(ctl), 32'd0);
    next_cycle();
    rst = 1'b0;
    #3;
    chk("rst_mid_md_error", 32'(md_error), 32'd0);
    chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_mid_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_mid_run", 32'(ctl), 32'd0);

    // md_done coinciding with the timeout cycle: no error.
    next_cycle();
    MulDiv_EX = 1'b1;
    #3;
    chk("tie_md_start", 32'(ctl), 32'(e(0, 0, 0, 0, 0, 0, 1, 0, 0)));
    for (int c = 1; c <= 7; c++) next_cycle();
    next_cycle();
    md_done = 1'b1;
    #3;
    chk("tie_release", 32'(ctl), 32'd0);
    next_cycle();
    MulDiv_EX = 1'b0;
    md_done = 1'b0;
    #3;
    chk("tie_md_error", 32'(md_error), 32'd0);
    chk("tie_stall_cnt", 32'(stall_cnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
